// File: rtl/vx_ifetch_tracker_pkg.sv
// Shared widths, tag layout and per-slot fetch metadata
// for the instruction-fetch tracker.
package vx_ifetch_tracker_pkg;

  localparam int NUM_WARPS   = 4;
  localparam int NUM_THREADS = 4;
  localparam int PENDING     = 2;

  localparam int NW_BITS =
    (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
  localparam int PS_BITS =
    (PENDING > 1) ? $clog2(PENDING) : 1;
  localparam int TAG_W = NW_BITS + PS_BITS;

  typedef logic [NW_BITS-1:0] wid_t;
  typedef logic [PS_BITS-1:0] slot_t;
  typedef logic [TAG_W-1:0]   tag_t;

  typedef struct packed {
    logic [31:0]            pc;
    logic [NUM_THREADS-1:0] tmask;
  } meta_t;

  function automatic tag_t tag_pack(
    input slot_t s,
    input wid_t  w
  );
    return {s, w};
  endfunction

  function automatic wid_t tag_wid(input tag_t t);
    return t[NW_BITS-1:0];
  endfunction

  function automatic slot_t tag_slot(input tag_t t);
    return t[TAG_W-1:NW_BITS];
  endfunction

endpackage

// File: rtl/vx_ifetch_slot_alloc.sv
// Lowest-free-slot priority encoder over one warp's
// in-flight bitmap.
module vx_ifetch_slot_alloc #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  busy,
  output logic [IW-1:0] idx,
  output logic          any_free
);

  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        idx      = IW'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_ifetch_tracker.sv
// Tracks outstanding I$ fetches per warp, drops flushed
// responses and registers the fetch response.
module vx_ifetch_tracker
  import vx_ifetch_tracker_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ifetch_req_valid,
  input  logic [NW_BITS-1:0]     ifetch_req_wid,
  input  logic [31:0]            ifetch_req_pc,
  input  logic [NUM_THREADS-1:0] ifetch_req_tmask,
  output logic                   ifetch_req_ready,
  input  logic                   flush_valid,
  input  logic [NW_BITS-1:0]     flush_wid,
  output logic                   icache_req_valid,
  output logic [29:0]            icache_req_addr,
  output logic [TAG_W-1:0]       icache_req_tag,
  input  logic                   icache_req_ready,
  input  logic                   icache_rsp_valid,
  input  logic [31:0]            icache_rsp_data,
  input  logic [TAG_W-1:0]       icache_rsp_tag,
  output logic                   icache_rsp_ready,
  output logic                   ifetch_rsp_valid,
  output logic [NW_BITS-1:0]     ifetch_rsp_wid,
  output logic [31:0]            ifetch_rsp_pc,
  output logic [NUM_THREADS-1:0] ifetch_rsp_tmask,
  output logic [31:0]            ifetch_rsp_instr,
  input  logic                   ifetch_rsp_ready,
  output logic [NUM_WARPS-1:0]   pending_mask
);

  logic [PENDING-1:0] sv_q [NUM_WARPS];
  logic [PENDING-1:0] st_q [NUM_WARPS];
  logic [PENDING-1:0] sv_d [NUM_WARPS];
  logic [PENDING-1:0] st_d [NUM_WARPS];

  meta_t meta_q [NUM_WARPS*PENDING];

  logic  out_valid;
  wid_t  out_wid;
  meta_t out_meta;
  logic [31:0] out_instr;

  slot_t alloc_idx;
  logic  any_free;
  logic  req_blk;
  logic  req_fire;

  wid_t  rsp_wid;
  slot_t rsp_slot;
  logic  rsp_live;
  logic  rsp_drop;
  logic  rsp_fire;
  logic  rsp_load;
  meta_t rsp_meta;

  logic  out_fire;
  logic  out_kill;

  logic [TAG_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_idx;

  logic unused_pc_lsb;

  vx_ifetch_slot_alloc #(
    .N  (PENDING),
    .IW (PS_BITS)
  ) u_alloc (
    .busy     (sv_q[ifetch_req_wid]),
    .idx      (alloc_idx),
    .any_free (any_free)
  );

  assign unused_pc_lsb = ^ifetch_req_pc[1:0];

  // request side never looks at icache_req_ready for valid
  assign req_blk = flush_valid
                 & (flush_wid == ifetch_req_wid);
  assign icache_req_valid = ifetch_req_valid
                          & any_free & ~req_blk;
  assign ifetch_req_ready = icache_req_ready
                          & any_free & ~req_blk;
  assign req_fire = icache_req_valid & icache_req_ready;
  assign icache_req_addr = ifetch_req_pc[31:2];
  assign icache_req_tag  = tag_pack(alloc_idx,
                                    ifetch_req_wid);

  assign rsp_wid  = tag_wid(icache_rsp_tag);
  assign rsp_slot = tag_slot(icache_rsp_tag);
  assign rsp_live = sv_q[rsp_wid][rsp_slot];
  assign rsp_drop = st_q[rsp_wid][rsp_slot]
                  | (flush_valid & (flush_wid == rsp_wid))
                  | ~rsp_live;

  assign out_fire = out_valid & ifetch_rsp_ready;
  assign out_kill = flush_valid & out_valid
                  & (out_wid == flush_wid);

  assign icache_rsp_ready = rsp_drop | ~out_valid
                          | ifetch_rsp_ready;
  assign rsp_fire = icache_rsp_valid & icache_rsp_ready;
  assign rsp_load = rsp_fire & ~rsp_drop;

  assign wr_idx = TAG_W'(ifetch_req_wid) * TAG_W'(PENDING)
                + TAG_W'(alloc_idx);
  assign rd_idx = TAG_W'(rsp_wid) * TAG_W'(PENDING)
                + TAG_W'(rsp_slot);
  assign rsp_meta = meta_q[rd_idx];

  always_comb begin
    sv_d = sv_q;
    st_d = st_q;
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int s = 0; s < PENDING; s++) begin
        logic fr;
        logic al;
        fr = rsp_fire
           & (rsp_wid == wid_t'(w))
           & (rsp_slot == slot_t'(s));
        al = req_fire
           & (ifetch_req_wid == wid_t'(w))
           & (alloc_idx == slot_t'(s));
        if (flush_valid && flush_wid == wid_t'(w)
            && sv_q[w][s] && !fr)
          st_d[w][s] = 1'b1;
        if (fr) begin
          sv_d[w][s] = 1'b0;
          st_d[w][s] = 1'b0;
        end
        if (al) begin
          sv_d[w][s] = 1'b1;
          st_d[w][s] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sv_q <= '{default: '0};
      st_q <= '{default: '0};
    end else begin
      sv_q <= sv_d;
      st_q <= st_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      meta_q[wr_idx] <= '{pc:    ifetch_req_pc,
                          tmask: ifetch_req_tmask};
  end

  // a fresh load wins over drain and over flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_wid   <= '0;
      out_meta  <= '0;
      out_instr <= '0;
    end else if (rsp_load) begin
      out_valid <= 1'b1;
      out_wid   <= rsp_wid;
      out_meta  <= rsp_meta;
      out_instr <= icache_rsp_data;
    end else if (out_fire || out_kill) begin
      out_valid <= 1'b0;
    end
  end

  assign ifetch_rsp_valid = out_valid;
  assign ifetch_rsp_wid   = out_wid;
  assign ifetch_rsp_pc    = out_meta.pc;
  assign ifetch_rsp_tmask = out_meta.tmask;
  assign ifetch_rsp_instr = out_instr;

  always_comb begin
    pending_mask = '0;
    for (int w = 0; w < NUM_WARPS; w++)
      pending_mask[w] = |sv_q[w];
  end

  a_rsp_live : assert property (
    @(posedge clk) disable iff (!reset)
    (icache_rsp_valid && icache_rsp_ready) |-> rsp_live
  );

endmodule
